// File: rtl/line_mem_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : line_mem_pkg
// Description : Shared types, default sizing and width helpers for the
//               line memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package line_mem_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_LATENCY    = 3;

    // Beat index width and latency counter width at the default sizing
    localparam int BEAT_W = $clog2(DEF_LINE_WORDS);
    localparam int CNT_W  = $clog2(DEF_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_WAIT  = 3'd1,
        S_RD_BURST = 3'd2,
        S_WR_BURST = 3'd3,
        S_WR_WAIT  = 3'd4,
        S_WR_ACK   = 3'd5
    } state_t;

    // Width needed to hold a down-counter loaded with (lat - 1); never zero
    function automatic int cnt_bits(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_store.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : line_store
// Description : Single-port synchronous storage array with a registered
//               read port (read-before-write). Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module line_store #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
)(
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // One shared address: write when enabled, always register the old word
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/line_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : line_mem_responder
// Description : Memory-side responder for cache line refill / write-back.
//               Reads return a LINE_WORDS burst after LATENCY cycles; writes
//               absorb a LINE_WORDS burst and return one acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module line_mem_responder
    import line_mem_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int LATENCY    = DEF_LATENCY
)(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic              resp_is_wack,
    output logic              busy
);

    localparam int L_BEAT_W = $clog2(LINE_WORDS);
    localparam int L_CNT_W  = cnt_bits(LATENCY);
    localparam logic [L_BEAT_W-1:0] C_LAST_BEAT = L_BEAT_W'(LINE_WORDS - 1);
    localparam logic [L_CNT_W-1:0]  C_CNT_LOAD  = L_CNT_W'(LATENCY - 1);

    state_t                     r_state;
    logic [ADDR_W-L_BEAT_W-1:0] r_line;
    logic [L_BEAT_W-1:0]        r_beat;
    logic [L_CNT_W-1:0]         r_cnt;
    logic                       r_req_ready;
    logic                       r_wdata_ready;
    logic                       r_resp_valid;
    logic                       r_resp_last;
    logic                       r_resp_is_wack;
    logic                       r_busy;

    logic                       w_req_fire;
    logic                       w_wr_fire;
    logic                       w_resp_fire;
    logic [L_BEAT_W-1:0]        w_beat_inc;
    logic [L_BEAT_W-1:0]        w_mem_beat;
    logic [ADDR_W-1:0]          w_mem_addr;
    logic [DATA_W-1:0]          w_rd_data;
    logic                       w_unused_addr_lo;

    assign w_req_fire  = req_valid   & r_req_ready;
    assign w_wr_fire   = wdata_valid & r_wdata_ready;
    assign w_resp_fire = r_resp_valid & resp_ready;
    assign w_beat_inc  = r_beat + L_BEAT_W'(1);

    // Pre-fetch: on a read handshake address the next beat so its word is
    // registered by the time it is presented; on a stall re-read the same one
    assign w_mem_beat = ((r_state == S_RD_BURST) && w_resp_fire) ? w_beat_inc : r_beat;
    // The line base is aligned, so concatenation gives base+beat mod 2**ADDR_W
    assign w_mem_addr = {r_line, w_mem_beat};

    // Low request address bits select nothing: requests are line aligned
    assign w_unused_addr_lo = ^req_addr[L_BEAT_W-1:0];

    line_store #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_store (
        .clk     (clock),
        .i_we    (w_wr_fire),
        .i_addr  (w_mem_addr),
        .i_wdata (wdata),
        .o_rdata (w_rd_data)
    );

    assign req_ready    = r_req_ready;
    assign wdata_ready  = r_wdata_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_last    = r_resp_last;
    assign resp_is_wack = r_resp_is_wack;
    assign busy         = r_busy;
    // Storage output is only meaningful during a read burst; zero otherwise
    assign resp_data    = (r_state == S_RD_BURST) ? w_rd_data : '0;

    // Request / burst sequencing with registered handshake outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_line         <= '0;
            r_beat         <= '0;
            r_cnt          <= '0;
            r_req_ready    <= 1'b0;
            r_wdata_ready  <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_resp_last    <= 1'b0;
            r_resp_is_wack <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_req_fire) begin
                        r_line      <= req_addr[ADDR_W-1:L_BEAT_W];
                        r_beat      <= '0;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (req_wr) begin
                            r_state       <= S_WR_BURST;
                            r_wdata_ready <= 1'b1;
                        end else begin
                            r_state <= S_RD_WAIT;
                            r_cnt   <= C_CNT_LOAD;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state      <= S_RD_BURST;
                        r_resp_valid <= 1'b1;
                        r_resp_last  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - L_CNT_W'(1);
                    end
                end
                S_RD_BURST: begin
                    if (w_resp_fire) begin
                        if (r_resp_last) begin
                            r_state      <= S_IDLE;
                            r_resp_valid <= 1'b0;
                            r_resp_last  <= 1'b0;
                            r_req_ready  <= 1'b1;
                            r_busy       <= 1'b0;
                            r_beat       <= '0;
                        end else begin
                            r_beat      <= w_beat_inc;
                            r_resp_last <= (w_beat_inc == C_LAST_BEAT);
                        end
                    end
                end
                S_WR_BURST: begin
                    if (w_wr_fire) begin
                        r_beat <= w_beat_inc;
                        if (r_beat == C_LAST_BEAT) begin
                            r_state       <= S_WR_WAIT;
                            r_wdata_ready <= 1'b0;
                            r_cnt         <= C_CNT_LOAD;
                        end
                    end
                end
                S_WR_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state        <= S_WR_ACK;
                        r_resp_valid   <= 1'b1;
                        r_resp_last    <= 1'b1;
                        r_resp_is_wack <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - L_CNT_W'(1);
                    end
                end
                S_WR_ACK: begin
                    if (w_resp_fire) begin
                        r_state        <= S_IDLE;
                        r_resp_valid   <= 1'b0;
                        r_resp_last    <= 1'b0;
                        r_resp_is_wack <= 1'b0;
                        r_req_ready    <= 1'b1;
                        r_busy         <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_line_mem_responder
// Description : Self-checking bench for line_mem_responder with a word-level
//               memory model and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_mem_responder;

    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int LW  = 4;
    localparam int LAT = 3;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic          wdata_valid;
    logic          wdata_ready;
    logic [DW-1:0] wdata;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          resp_last;
    logic          resp_is_wack;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // Reference model: one word per address plus a written flag
    logic [DW-1:0] mdl   [0:DEPTH-1];
    bit            known [0:DEPTH-1];

    line_mem_responder #(
        .DATA_W(DW), .ADDR_W(AW), .LINE_WORDS(LW), .LATENCY(LAT)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_last(resp_last), .resp_is_wack(resp_is_wack), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int waddr(input int a, input int i);
        return ((a / LW) * LW + i) % DEPTH;
    endfunction

    // Wait for req_ready, present a request for one cycle
    task automatic start_req(input bit wr, input logic [AW-1:0] a, output bit ok);
        int c;
        c = 0;
        while (req_ready !== 1'b1 && c < 50) begin @(negedge clock); c++; end
        ok = (req_ready === 1'b1);
        req_valid = 1'b1; req_wr = wr; req_addr = a;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    // Write a line (optionally with idle gaps), update the model, take the ack
    task automatic write_line(input logic [AW-1:0] a, input logic [LW-1:0][DW-1:0] d,
                              input bit gaps, output int rdy_bad, output int lat,
                              output logic wack, output logic last,
                              output logic [DW-1:0] adata, output logic wrdy_at_ack);
        bit ok, gap;
        int i, cyc;
        start_req(1'b1, a, ok);
        rdy_bad = ok ? 0 : 1;
        i = 0; cyc = 0;
        while (i < LW && cyc < 100) begin
            gap = gaps && ($urandom_range(0, 3) == 0);
            if (wdata_ready !== 1'b1) rdy_bad++;
            wdata_valid = !gap;
            wdata = gap ? DW'($urandom) : d[i];
            if (!gap) begin
                mdl[waddr(a, i)] = d[i];
                known[waddr(a, i)] = 1'b1;
                i++;
            end
            @(negedge clock); cyc++;
        end
        wdata_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 40) begin @(negedge clock); lat++; end
        wack = resp_is_wack; last = resp_last; adata = resp_data; wrdy_at_ack = wdata_ready;
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
    endtask

    // Collect a read burst after the request was accepted.
    // mode 0: always ready, 1: ready pattern 1,0,0,1,0,1,1 then 1, 2: random
    task automatic collect_read(input int mode, output logic [LW-1:0][DW-1:0] d,
                                output int lat, output int last_bad, output int stab_bad,
                                output int hs, output int rr_hi, output int wr_hi);
        logic [6:0]  pat;
        logic [LW-1:0] lastv;
        logic [DW-1:0] hd;
        logic        hl, held, rdy;
        int          k, cyc;
        pat = 7'b1101001;   // bit n = ready on stall-loop cycle n
        lat = 0; rr_hi = 0; wr_hi = 0; stab_bad = 0; last_bad = 0;
        d = '0; lastv = '0; hd = '0; hl = 1'b0;
        while (resp_valid !== 1'b1 && lat < 40) begin
            if (req_ready === 1'b1) rr_hi++;
            if (wdata_ready === 1'b1) wr_hi++;
            @(negedge clock); lat++;
        end
        k = 0; cyc = 0; held = 1'b0;
        while (k < LW && cyc < 200) begin
            if (resp_valid !== 1'b1) stab_bad++;
            if (held && (resp_data !== hd || resp_last !== hl)) stab_bad++;
            if (resp_is_wack !== 1'b0) stab_bad++;
            if (req_ready === 1'b1) rr_hi++;
            if (wdata_ready === 1'b1) wr_hi++;
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (cyc < 7) ? pat[cyc] : 1'b1;
            else                rdy = 1'($urandom_range(0, 1));
            resp_ready = rdy;
            if (rdy) begin
                d[k] = resp_data; lastv[k] = resp_last; k++; held = 1'b0;
            end else begin
                held = 1'b1; hd = resp_data; hl = resp_last;
            end
            @(negedge clock); cyc++;
        end
        resp_ready = 1'b0;
        hs = k;
        for (int j = 0; j < LW; j++)
            if (lastv[j] !== (j == LW - 1)) last_bad++;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
        wdata_valid = 1'b0; wdata = '0; resp_ready = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if ({req_ready, wdata_ready, resp_valid, resp_last, resp_is_wack, busy} !== 6'b0 || resp_data !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got rr=%b wr=%b rv=%b rl=%b wk=%b bz=%b rd=%0h want all 0",
                     req_ready, wdata_ready, resp_valid, resp_last, resp_is_wack, busy, resp_data);
        end
        reset_n = 1'b1;
        @(negedge clock);
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle: got rr=%b bz=%b want rr=1 bz=0", req_ready, busy);
        end
    endtask

    task automatic test_write_basic;
        logic [LW-1:0][DW-1:0] d;
        int rb, lat;
        logic wk, ls, wr;
        logic [DW-1:0] ad;
        for (int i = 0; i < LW; i++) d[i] = DW'(32'hA0 + i);
        write_line(10'h010, d, 1'b0, rb, lat, wk, ls, ad, wr);
        total++; if (rb !== 0)   begin bad++; $display("FAIL wr_ready_run: got %0d low cycles want 0", rb); end
        total++; if (lat !== LAT) begin bad++; $display("FAIL wack_latency: got %0d want %0d", lat, LAT); end
        total++; if ({wk, ls} !== 2'b11 || ad !== '0 || wr !== 1'b0) begin
            bad++; $display("FAIL wack_fields: got wk=%b last=%b data=%0h wrdy=%b want 1 1 0 0", wk, ls, ad, wr);
        end
        total++; if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL wack_done: got rv=%b bz=%b rr=%b want 0 0 1", resp_valid, busy, req_ready);
        end
    endtask

    // Read a line with a given readiness mode and check it against the model
    task automatic test_read(input string nm, input logic [AW-1:0] a, input int mode);
        logic [LW-1:0][DW-1:0] d;
        int lat, lb, sb, hs, rr, wr;
        bit ok;
        start_req(1'b0, a, ok);
        collect_read(mode, d, lat, lb, sb, hs, rr, wr);
        total++; if (lat !== LAT) begin bad++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, LAT); end
        for (int i = 0; i < LW; i++) begin
            if (known[waddr(a, i)]) begin
                total++;
                if (d[i] !== mdl[waddr(a, i)]) begin
                    bad++; $display("FAIL %s_beat%0d: got %0h want %0h", nm, i, d[i], mdl[waddr(a, i)]);
                end
            end
        end
        total++; if (lb !== 0 || sb !== 0 || hs !== LW) begin
            bad++; $display("FAIL %s_handshake: got last_bad=%0d stab_bad=%0d hs=%0d want 0 0 %0d", nm, lb, sb, hs, LW);
        end
        total++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL %s_end: got rv=%b bz=%b want 0 0", nm, resp_valid, busy);
        end
    endtask

    task automatic test_wrap;
        logic [LW-1:0][DW-1:0] d;
        int rb, lat;
        logic wk, ls, wr;
        logic [DW-1:0] ad;
        for (int i = 0; i < LW; i++) d[i] = DW'(32'h5500 + i);
        write_line(10'h000, d, 1'b0, rb, lat, wk, ls, ad, wr);
        for (int i = 0; i < LW; i++) d[i] = DW'(i + 1);
        write_line(10'h3FC, d, 1'b0, rb, lat, wk, ls, ad, wr);
        total++; if (lat !== LAT || rb !== 0) begin
            bad++; $display("FAIL wrap_write: got lat=%0d rdy_bad=%0d want %0d 0", lat, rb, LAT);
        end
        test_read("wrap_hi", 10'h3FE, 0);
        test_read("wrap_lo", 10'h000, 0);
    endtask

    task automatic test_req_ignored;
        logic [LW-1:0][DW-1:0] d;
        int lat, lb, sb, hs, rr, wr;
        bit ok;
        start_req(1'b0, 10'h012, ok);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 10'h3FD;
        wdata_valid = 1'b1; wdata = 32'hDEAD_BEEF;
        collect_read(2, d, lat, lb, sb, hs, rr, wr);
        total++; if (rr !== 0 || wr !== 0) begin
            bad++; $display("FAIL ign_ready: got req_ready_hi=%0d wdata_ready_hi=%0d want 0 0", rr, wr);
        end
        for (int i = 0; i < LW; i++) begin
            total++;
            if (d[i] !== mdl[waddr(10'h010, i)]) begin
                bad++; $display("FAIL ign_beat%0d: got %0h want %0h", i, d[i], mdl[waddr(10'h010, i)]);
            end
        end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ign_accept_slot: got rr=%b want 1", req_ready); end
        @(negedge clock);
        req_valid = 1'b0; wdata_valid = 1'b0;
        collect_read(0, d, lat, lb, sb, hs, rr, wr);
        total++; if (lat !== LAT) begin bad++; $display("FAIL ign_second_latency: got %0d want %0d", lat, LAT); end
        for (int i = 0; i < LW; i++) begin
            total++;
            if (d[i] !== DW'(i + 1)) begin bad++; $display("FAIL ign_second_beat%0d: got %0h want %0h", i, d[i], i + 1); end
        end
    endtask

    task automatic test_reset_midwrite;
        bit ok;
        start_req(1'b1, 10'h041, ok);
        wdata_valid = 1'b1; wdata = 32'hC0;
        @(negedge clock);
        wdata = 32'hC1;
        @(negedge clock);
        mdl[10'h040] = 32'hC0; known[10'h040] = 1'b1;
        mdl[10'h041] = 32'hC1; known[10'h041] = 1'b1;
        wdata_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        total++;
        if ({req_ready, wdata_ready, resp_valid, resp_last, resp_is_wack, busy} !== 6'b0 || resp_data !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: got rr=%b wr=%b rv=%b rl=%b wk=%b bz=%b rd=%0h want all 0",
                     req_ready, wdata_ready, resp_valid, resp_last, resp_is_wack, busy, resp_data);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        total++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL midreset_idle: got rr=%b bz=%b want 1 0", req_ready, busy);
        end
        test_read("midreset_read", 10'h040, 0);
    endtask

    task automatic test_random;
        logic [LW-1:0][DW-1:0] d;
        logic [AW-1:0] lines[$];
        logic [AW-1:0] a;
        int rb, lat;
        logic wk, ls, wr;
        logic [DW-1:0] ad;
        for (int n = 0; n < 12; n++) begin
            if (lines.size() == 0 || $urandom_range(0, 1) == 1) begin
                a = AW'($urandom_range(0, DEPTH - 1));
                for (int i = 0; i < LW; i++) d[i] = DW'($urandom);
                write_line(a, d, 1'b1, rb, lat, wk, ls, ad, wr);
                lines.push_back(a);
                total++; if (rb !== 0 || lat !== LAT || wk !== 1'b1 || ls !== 1'b1 || ad !== '0) begin
                    bad++; $display("FAIL rnd_write: got rdy_bad=%0d lat=%0d wk=%b last=%b data=%0h want 0 %0d 1 1 0",
                                    rb, lat, wk, ls, ad, LAT);
                end
            end else begin
                a = lines[$urandom_range(0, lines.size() - 1)] ^ AW'($urandom_range(0, LW - 1));
                test_read("rnd_read", a, 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read("rd_basic", 10'h013, 0);
        test_read("rd_stall", 10'h011, 1);
        test_wrap();
        test_req_ignored();
        test_reset_midwrite();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
